// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO registers.
//   Performs one radix-2 step per cycle on operand magnitudes: shift-add for
//   multiply and restoring division for divide. Signs are fixed up in the
//   DONE state, and the result is written to HI/LO on the edge that ends DONE.
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   start_i, op_i         request; op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data_i, rt_data_i  operands (dividend = rs, divisor = rt)
//   kill_i                flush of the requesting instruction
//   rd_hilo_i             mfhi/mflo in EX
//   wr_hi_i, wr_lo_i      mthi/mtlo write enables; wdata_i is the write data
//   stall_o, busy_o       pipeline stall request; busy_o is high when not idle
//   done_o                one-cycle completion pulse
//   hi_o, lo_o            HI/LO register contents
module muldiv_unit #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DWIDTH-1:0] rs_data_i,
    input  logic [DWIDTH-1:0] rt_data_i,
    input  logic              kill_i,
    input  logic              rd_hilo_i,
    input  logic              wr_hi_i,
    input  logic              wr_lo_i,
    input  logic [DWIDTH-1:0] wdata_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DWIDTH-1:0] hi_o,
    output logic [DWIDTH-1:0] lo_o
);
    localparam int CW = $clog2(DWIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic                is_div_q, neg_main_q, neg_rem_q, div_zero_q;
    logic [DWIDTH-1:0]   opnd_q;   // multiplicand (mul) or divisor (div) magnitude
    logic [DWIDTH-1:0]   rs_q;     // raw dividend, returned in HI on divide-by-zero
    logic [2*DWIDTH-1:0] acc;      // mul: {partial, multiplier}; div: {rem, quot}
    logic [DWIDTH-1:0]   hi_q, lo_q;

    logic                accept, sgn_op, rs_neg, rt_neg;
    logic [DWIDTH-1:0]   rs_mag, rt_mag;
    logic [DWIDTH:0]     mul_sum, div_trial;
    logic                div_ok;
    logic [2*DWIDTH-1:0] mul_next, div_next, prod_fix;
    logic [DWIDTH-1:0]   quot_fix, rem_fix, res_hi, res_lo;

    assign accept = (state == IDLE) & start_i & ~kill_i;
    assign sgn_op = ~op_i[0];
    assign rs_neg = sgn_op & rs_data_i[DWIDTH-1];
    assign rt_neg = sgn_op & rt_data_i[DWIDTH-1];
    assign rs_mag = rs_neg ? -rs_data_i : rs_data_i;
    assign rt_mag = rt_neg ? -rt_data_i : rt_data_i;

    // Shift-add step: the carry out of the partial sum shifts into the top bit.
    assign mul_sum  = {1'b0, acc[2*DWIDTH-1:DWIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc[DWIDTH-1:1]};

    // Restoring step: trial-subtract the divisor from the shifted remainder.
    // The remainder stays below the divisor, so the shift fits in DWIDTH+1 bits.
    assign div_trial = acc[2*DWIDTH-1:DWIDTH-1] - {1'b0, opnd_q};
    assign div_ok    = ~div_trial[DWIDTH];
    assign div_next  = {div_ok ? div_trial[DWIDTH-1:0] : acc[2*DWIDTH-2:DWIDTH-1],
                        acc[DWIDTH-2:0], div_ok};

    // Sign fixup. Most-negative / -1 comes out naturally as most-negative with
    // remainder 0, because negating 2^(DWIDTH-1) wraps to itself.
    assign prod_fix = neg_main_q ? -acc : acc;
    assign quot_fix = neg_main_q ? -acc[DWIDTH-1:0] : acc[DWIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc[2*DWIDTH-1:DWIDTH] : acc[2*DWIDTH-1:DWIDTH];

    always_comb begin
        res_hi = prod_fix[2*DWIDTH-1:DWIDTH];
        res_lo = prod_fix[DWIDTH-1:0];
        if (is_div_q) begin
            res_hi = div_zero_q ? rs_q : rem_fix;
            res_lo = div_zero_q ? '1   : quot_fix;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (kill_i) state_nxt = IDLE;
                     else if (cnt == CW'(DWIDTH - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            is_div_q   <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            opnd_q     <= '0;
            rs_q       <= '0;
            acc        <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt        <= '0;
                is_div_q   <= op_i[1];
                neg_main_q <= rs_neg ^ rt_neg;
                neg_rem_q  <= op_i[1] & rs_neg;
                div_zero_q <= (rt_data_i == '0);
                rs_q       <= rs_data_i;
                opnd_q     <= op_i[1] ? rt_mag : rs_mag;
                acc        <= {{DWIDTH{1'b0}}, op_i[1] ? rs_mag : rt_mag};
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
                acc <= is_div_q ? div_next : mul_next;
            end
        end
    end

    // A killed operation never reaches HI/LO. mthi/mtlo lose to an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == DONE) begin
            if (!kill_i) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end else if (state == IDLE && !accept) begin
            if (wr_hi_i) hi_q <= wdata_i;
            if (wr_lo_i) lo_q <= wdata_i;
        end
    end

    // stall_o is gated by rst_n so that a start held during reset does not stall.
    assign stall_o = rst_n & (accept | (state == BUSY) | (rd_hilo_i & (state == BUSY)));
    assign busy_o  = (state != IDLE);
    assign done_o  = (state == DONE);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i, kill_i, rd_hilo_i, wr_hi_i, wr_lo_i;
    logic [1:0]    op_i;
    logic [DW-1:0] rs_data_i, rt_data_i, wdata_i;
    logic          stall_o, busy_o, done_o;
    logic [DW-1:0] hi_o, lo_o;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .kill_i(kill_i),
        .rd_hilo_i(rd_hilo_i), .wr_hi_i(wr_hi_i), .wr_lo_i(wr_lo_i),
        .wdata_i(wdata_i), .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [1:0]    op;
        logic [DW-1:0] rs, rt, ehi, elo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference results from plain signed/unsigned arithmetic.
    task automatic model(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         output logic [DW-1:0] hi, output logic [DW-1:0] lo);
        longint     sp;
        logic [63:0] up;
        int         sa, sb;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin sp = longint'(sa) * longint'(sb); up = sp; hi = up[63:32]; lo = up[31:0]; end
            2'b01: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; end
            2'b10: begin
                if (b == 0) begin hi = a; lo = '1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin hi = 0; lo = 32'h8000_0000; end
                else begin lo = sa / sb; hi = sa % sb; end
            end
            default: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endtask

    // Called at posedge+1 (cycle 0); returns at posedge+1 after HI/LO are checked.
    task automatic run_op(input string nm, input logic [1:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [DW-1:0] ehi, input logic [DW-1:0] elo);
        int stall_cnt = 0;
        int done_cyc  = -1;
        bit got       = 0;
        op_i = op; rs_data_i = a; rt_data_i = b; start_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            stall_cnt += int'(stall_o);
            if (done_o && done_cyc < 0) done_cyc = c;
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                chk({nm, "_hi"}, hi_o, ehi);
                chk({nm, "_lo"}, lo_o, elo);
                got = 1;
                break;
            end
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        start_i = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no done_o expected done within 40 cycles", nm);
        end else begin
            chk({nm, "_stall_cycles"}, stall_cnt, DW + 1);
            chk({nm, "_done_cycle"}, done_cyc, DW + 1);
        end
        @(posedge clk); #1;
    endtask

    // Waits for done_o, then one more edge so the result is in HI/LO.
    task automatic wait_done(input string nm);
        bit got = 0;
        for (int c = 0; c < 40; c++) begin
            if (done_o) begin got = 1; break; end
            @(posedge clk); #1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no done_o expected done within 40 cycles", nm);
        end
        @(posedge clk); #1;
    endtask

    task automatic write_hilo(input bit hi, input logic [DW-1:0] d);
        wdata_i = d; wr_hi_i = hi; wr_lo_i = ~hi;
        @(posedge clk); #1;
        wr_hi_i = 0; wr_lo_i = 0;
    endtask

    initial begin
        logic [DW-1:0] rh, rl, ra, rb;
        logic [1:0]    rop;
        int            seen;

        vecs.push_back('{"multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{"div_m7_2",  2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{"divu_by0",  2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF});
        vecs.push_back('{"div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000});
        vecs.push_back('{"mult_m3_5", 2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1});
        vecs.push_back('{"div_7_m2",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD});
        vecs.push_back('{"div_m5_0",  2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF});
        vecs.push_back('{"mult_minsq",2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0});
        vecs.push_back('{"divu_max_1",2'b11, 32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF});
        vecs.push_back('{"mult_m1_m1",2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1});

        rst_n = 0; start_i = 1; kill_i = 0; rd_hilo_i = 0; wr_hi_i = 0; wr_lo_i = 0;
        op_i = 0; rs_data_i = 0; rt_data_i = 0; wdata_i = 0;
        #12;
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_stall", stall_o, 0);
        start_i = 0;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].ehi, vecs[i].elo);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 9);
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, rh, rl);
            run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, rh, rl);
        end

        // mthi in IDLE, then preload HI/LO for the kill sequence.
        write_hilo(1, 32'hAA);
        chk("mthi_idle", hi_o, 32'hAA);
        write_hilo(1, 32'h1234);
        write_hilo(0, 32'h5678);

        // Kill at BUSY cycle 10.
        op_i = 2'b01; rs_data_i = 32'hFFFF_FFFF; rt_data_i = 32'hFFFF_FFFF; start_i = 1;
        @(posedge clk); #1; start_i = 0;
        repeat (9) begin @(posedge clk); #1; end
        kill_i = 1;
        @(posedge clk); #1; kill_i = 0;
        chk("kill_busy", busy_o, 0);
        chk("kill_stall", stall_o, 0);
        chk("kill_done", done_o, 0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done_o) seen++;
            @(posedge clk); #1;
        end
        chk("kill_no_done", seen, 0);
        chk("kill_hi", hi_o, 32'h1234);
        chk("kill_lo", lo_o, 32'h5678);

        // mthi during BUSY is ignored.
        op_i = 2'b01; rs_data_i = 3; rt_data_i = 4; start_i = 1;
        @(posedge clk); #1; start_i = 0;
        repeat (4) begin @(posedge clk); #1; end
        wdata_i = 32'hBEEF; wr_hi_i = 1;
        @(posedge clk); #1; wr_hi_i = 0;
        chk("mthi_busy", hi_o, 32'h1234);
        wait_done("mthi_busy_op");
        chk("mthi_busy_res_hi", hi_o, 0);
        chk("mthi_busy_res_lo", lo_o, 12);

        // start and mtlo in the same IDLE cycle: only the result lands.
        op_i = 2'b01; rs_data_i = 5; rt_data_i = 6; start_i = 1; wdata_i = 32'h77; wr_lo_i = 1;
        @(posedge clk); #1; start_i = 0; wr_lo_i = 0;
        chk("mtlo_with_start", lo_o, 12);
        wait_done("mtlo_start_op");
        chk("mtlo_start_res_lo", lo_o, 30);

        // Asynchronous reset mid-operation.
        write_hilo(1, 32'hAA);
        write_hilo(0, 32'h99);
        op_i = 2'b01; rs_data_i = 3; rt_data_i = 4; start_i = 1;
        @(posedge clk); #1; start_i = 0;
        repeat (4) begin @(posedge clk); #1; end
        #2 rst_n = 0;
        #1;
        chk("arst_hi", hi_o, 0);
        chk("arst_lo", lo_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_stall", stall_o, 0);
        chk("arst_done", done_o, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        chk("arst_idle_after", busy_o, 0);
        run_op("post_rst_multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, operand/result width; iteration count equals DWIDTH.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  EX-stage mult/div request.
REQ-005 SHALL have port op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port rs_data_i, rt_data_i  input  DWIDTH each  operands (dividend = rs, divisor = rt).
REQ-007 SHALL have port kill_i  input  1  pipeline flush of the requesting instruction.
REQ-008 SHALL have port rd_hilo_i  input  1  mfhi/mflo in EX.
REQ-009 SHALL have port wr_hi_i, wr_lo_i  input  1 each  mthi/mtlo write enables; wdata_i  input  DWIDTH  write data.
REQ-010 SHALL have port stall_o  output  1  stall request to the hazard controller's stall input.
REQ-011 SHALL have port busy_o  output  1  state != IDLE; done_o  output  1  one-cycle completion pulse.
REQ-012 SHALL have port hi_o, lo_o  output  DWIDTH each  registered HI/LO.

Function
REQ-013 SHALL implement FSM IDLE, BUSY, DONE with a log2(DWIDTH)+1-bit iteration counter.
REQ-014 SHALL, in IDLE with start_i=1 and kill_i=0, latch op and operand magnitudes (two's-complement negation for signed ops with negative operand) and enter BUSY, counter=0.
REQ-015 SHALL in BUSY perform one radix-2 step per cycle (shift-add multiply / restoring divide on magnitudes), advancing to DONE after DWIDTH steps.
REQ-016 SHALL in DONE apply sign fixup and write HI/LO on the edge ending DONE, then return to IDLE.
REQ-017 SHALL place result as: multiply HI=product[2*DWIDTH-1:DWIDTH], LO=product[DWIDTH-1:0]; divide LO=quotient, HI=remainder.
REQ-018 SHALL negate product when operand signs differ (MULT); for DIV negate quotient when signs differ, give remainder the dividend's sign.
REQ-019 SHALL on divisor zero produce LO=all ones, HI=dividend (raw rs value), signed and unsigned alike.
REQ-020 SHALL for DIV of most-negative by -1 produce LO=most-negative (0x80000000), HI=0.
REQ-021 SHALL drive stall_o = (IDLE & start_i & ~kill_i) | BUSY | (rd_hilo_i & BUSY); stall_o low in DONE.
REQ-022 SHALL assert done_o only during DONE; busy_o during BUSY and DONE.
REQ-023 Latency: start at cycle 0 -> BUSY cycles 1..DWIDTH -> DONE cycle DWIDTH+1 -> new HI/LO visible cycle DWIDTH+2; stall_o high cycles 0..DWIDTH.
REQ-024 SHALL ignore start_i outside IDLE.
REQ-025 SHALL on kill_i in BUSY or DONE return to IDLE next edge, leave HI/LO unchanged, suppress done_o next cycle.
REQ-026 SHALL in IDLE with kill_i=1 and start_i=1 not accept the request; stall_o low.
REQ-027 SHALL apply wr_hi_i/wr_lo_i only in IDLE with no accepted start; ignored in BUSY/DONE and when a start is accepted same cycle.
REQ-028 SHALL drive hi_o/lo_o directly from the HI/LO registers (no bypass of in-flight results).

Reset
REQ-029 SHALL on rst_n=0 immediately force state IDLE, counter 0, HI=LO=0, stall_o=0, busy_o=0, done_o=0, regardless of clk.
REQ-030 SHALL on reset mid-operation discard the operation; first edge after release sees IDLE.

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> stall_o high 33 cycles, done_o at cycle 33, HI=0xFFFFFFFE, LO=0x00000001 at cycle 34.
REQ-032 DIV -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU 100/0 -> LO=0xFFFFFFFF, HI=100.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; MULT -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-034 kill_i at BUSY cycle 10 of a MULTU with HI/LO=0x1234/0x5678 -> IDLE next cycle, stall_o low, no done_o, HI/LO unchanged.
REQ-035 rst_n low at BUSY cycle 5 -> outputs zero without clock edge; start pulse after release completes normally in 33 cycles.
REQ-036 mthi 0xAA in IDLE -> hi_o=0xAA next cycle; mthi during BUSY -> HI unchanged; start+wr_lo same IDLE cycle -> LO written only by result.
